// File: rtl/uart_freq_cmd.sv
// uart_freq_cmd: ASCII command decoder sitting between the UART receiver and
// the DDS address controller / wave mux. Decimal digits build a frequency in
// Hz; 's' applies it by converting Hz to a 32-bit phase increment with a
// 27-step LSB-first shift-add multiply; 'q'/'r'/'t' pick sine/rect/tri.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure. A byte is
// consumed in the cycle rx_valid is high. Bytes that arrive while the
// multiplier is running or finishing are dropped and flagged on err.
// All outputs are registered. There is no combinational path from rx_* to any
// output.
module uart_freq_cmd #(
  parameter int unsigned FTW_K      = 90071993,
  parameter int unsigned FTW_SHIFT  = 20,
  parameter int unsigned MAX_DIGITS = 8,
  parameter int unsigned MAX_FREQ   = 25000000,
  parameter logic [31:0] RST_FTW    = 32'd85899
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] freq_word,
  output logic        freq_update,
  output logic [3:0]  wave_sel,
  output logic        wave_update,
  output logic        busy,
  output logic        err
);

  localparam int unsigned MUL_STEPS = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [26:0] acc;
  logic [3:0]  cnt;
  logic [26:0] mcand;
  logic [53:0] addend;
  logic [53:0] prod;
  logic [4:0]  step;
  // A byte dropped in DONE shares its cycle with freq_update, so its err
  // pulse is pushed one cycle later to keep err and freq_update disjoint.
  logic        err_pend;

  logic is_digit;
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

  // Product bits outside the selected window are discarded by design.
  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod[53:52], prod[19:0]};

  // Command decode, multiplier sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      mcand       <= '0;
      addend      <= '0;
      prod        <= '0;
      step        <= '0;
      err_pend    <= 1'b0;
      freq_word   <= RST_FTW;
      freq_update <= 1'b0;
      wave_sel    <= 4'b1000;
      wave_update <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      freq_update <= 1'b0;
      wave_update <= 1'b0;
      err         <= err_pend;
      err_pend    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (is_digit) begin
              if (cnt < 4'(MAX_DIGITS)) begin
                acc <= acc * 27'd10 + {23'd0, rx_data[3:0]};
                cnt <= cnt + 4'd1;
              end else begin
                acc <= '0;
                cnt <= '0;
                err <= 1'b1;
              end
            end else begin
              case (rx_data)
                8'h73: begin // 's'
                  acc <= '0;
                  cnt <= '0;
                  if ((cnt == 4'd0) || (acc > 27'(MAX_FREQ))) begin
                    err <= 1'b1;
                  end else begin
                    mcand  <= acc;
                    addend <= {27'd0, 27'(FTW_K)};
                    prod   <= '0;
                    step   <= 5'(MUL_STEPS - 1);
                    busy   <= 1'b1;
                    state  <= MUL;
                  end
                end
                8'h71: begin wave_sel <= 4'b1000; wave_update <= 1'b1; end
                8'h72: begin wave_sel <= 4'b0100; wave_update <= 1'b1; end
                8'h74: begin wave_sel <= 4'b0010; wave_update <= 1'b1; end
                8'h0D, 8'h0A, 8'h20: ; // whitespace is ignored
                default: begin
                  acc <= '0;
                  cnt <= '0;
                  err <= 1'b1;
                end
              endcase
            end
          end
        end
        MUL: begin
          if (rx_valid) err <= 1'b1;
          if (mcand[0]) prod <= prod + addend;
          mcand  <= mcand >> 1;
          addend <= addend << 1;
          if (step == 5'd0) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            step <= step - 5'd1;
          end
        end
        DONE: begin
          if (rx_valid) err_pend <= 1'b1;
          freq_word   <= prod[FTW_SHIFT +: 32];
          freq_update <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
